// File: rtl/forth_pkg.sv
// Shared encodings and the control-word layout for the Forth decoder pipe.
// No logic; constants, types and the NOP word only.
// Imported by the op table and the pipeline top.
package forth_pkg;

    // Primary opcodes (low 3 bits of the opcode byte)
    localparam logic [2:0] OP_BLK = 3'd0;
    localparam logic [2:0] OP_RIT = 3'd1;
    localparam logic [2:0] OP_GET = 3'd2;
    localparam logic [2:0] OP_YNK = 3'd3;
    localparam logic [2:0] OP_DBL = 3'd4;
    localparam logic [2:0] OP_MIN = 3'd5;
    localparam logic [2:0] OP_CAL = 3'd6;
    localparam logic [2:0] OP_WHT = 3'd7;

    // YNK sub-opcodes; 1nn addresses J shadow register nn
    localparam logic [2:0] YNK_POPJ = 3'b000;
    localparam logic [2:0] YNK_POPS = 3'b001;

    // A mux select
    localparam logic [1:0] ISEL_REGI = 2'b00;
    localparam logic [1:0] ISEL_REGJ = 2'b01;
    localparam logic [1:0] ISEL_REGS = 2'b10;

    // I register update
    localparam logic [1:0] IF_HOLD = 2'b00;
    localparam logic [1:0] IF_INC  = 2'b01;
    localparam logic [1:0] IF_LOAD = 2'b10;

    // J register update
    localparam logic [2:0] JF_HOLD = 3'b000;
    localparam logic [2:0] JF_INC  = 3'b001;
    localparam logic [2:0] JF_LOAD = 3'b010;

    // F register update
    localparam logic [1:0] FF_HOLD = 2'b00;
    localparam logic [1:0] FF_SET  = 2'b01;
    localparam logic [1:0] FF_PUSH = 2'b11;

    // S register update
    localparam logic [1:0] SF_HOLD = 2'b00;
    localparam logic [1:0] SF_INC  = 2'b01;
    localparam logic [1:0] SF_DEC  = 2'b10;
    localparam logic [1:0] SF_LOAD = 2'b11;

    // ALU function
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOP = 2'b10;
    localparam logic [1:0] ALU_SUB = 2'b11;

    typedef struct packed {
        logic [1:0] a_sel;
        logic       b_sel;
        logic       c_sel;
        logic       d_sel;
        logic       d_f;
        logic [1:0] f_f;
        logic [1:0] i_f;
        logic [2:0] j_f;
        logic [1:0] s_f;
        logic       h_f;
        logic       t_f;
        logic [1:0] alu_f;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP = '{
        a_sel: ISEL_REGI, b_sel: 1'b0, c_sel: 1'b0, d_sel: 1'b0, d_f: 1'b0,
        f_f: FF_HOLD, i_f: IF_HOLD, j_f: JF_HOLD, s_f: SF_HOLD,
        h_f: 1'b0, t_f: 1'b0, alu_f: ALU_NOP
    };

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } dec_state_t;

endpackage

// File: rtl/forth_decoder_pipe_if.sv
// Opcode-in / control-word-out channel of the decoder pipe.
// Wires only, no latency.
// op_valid/op_ready and ctrl_valid/ctrl_ready are plain valid/ready pairs.
interface forth_decoder_pipe_if #(
    parameter int OP_W  = 3,
    parameter int XOP_W = 3,
    parameter int CNT_W = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [OP_W-1:0]  opcode;
    logic [XOP_W-1:0] xop;
    logic             ctrl_valid;
    logic             ctrl_ready;
    logic [1:0]       A_Sel;
    logic             B_Sel, C_Sel, D_Sel, D_F, H_F, T_F;
    logic [1:0]       ALU_F, I_F, S_F, F_F;
    logic [2:0]       J_F;
    logic             trap;
    logic             trap_clr;
    logic [CNT_W-1:0] retired;

    modport master (
        output op_valid, opcode, xop, ctrl_ready, trap_clr,
        input  op_ready, ctrl_valid, A_Sel, B_Sel, C_Sel, D_Sel, D_F, H_F, T_F,
               ALU_F, I_F, S_F, F_F, J_F, trap, retired
    );

    modport slave (
        input  op_valid, opcode, xop, ctrl_ready, trap_clr,
        output op_ready, ctrl_valid, A_Sel, B_Sel, C_Sel, D_Sel, D_F, H_F, T_F,
               ALU_F, I_F, S_F, F_F, J_F, trap, retired
    );
endinterface

// File: rtl/forth_op_table.sv
// Opcode/xop decode table producing one control word plus illegal/taken-CAL flags.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is used.
module forth_op_table
    import forth_pkg::*;
#(
    parameter int OP_W     = 3,
    parameter int XOP_W    = 3,
    parameter int JREG_CNT = 4
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic [XOP_W-1:0] xop,
    input  logic             reg_f,
    output ctrl_word_t       cw,
    output logic             illegal,
    output logic             taken_cal
);

    logic       op_hi;
    logic       xop_hi;
    logic [2:0] op3;
    logic [2:0] x3;

    // Anything above the low 3 bits must be zero for the op to be legal
    assign op_hi  = (opcode >> 3) != '0;
    assign xop_hi = (xop >> 3) != '0;
    assign op3    = opcode[2:0];
    assign x3     = xop[2:0];

    // Table lookup; fields not named for an op keep their NOP value
    always_comb begin
        cw        = CW_NOP;
        illegal   = op_hi;
        taken_cal = 1'b0;
        if (!op_hi) begin
            case (op3)
                OP_BLK: begin
                    cw.i_f = IF_INC; cw.t_f = 1'b1; cw.alu_f = ALU_ADD;
                end
                OP_RIT: begin
                    cw.a_sel = ISEL_REGJ; cw.d_f = 1'b1; cw.i_f = IF_INC; cw.j_f = JF_INC;
                end
                OP_GET: begin
                    cw.a_sel = ISEL_REGJ; cw.i_f = IF_INC; cw.j_f = JF_INC; cw.t_f = 1'b1;
                end
                OP_YNK: begin
                    if (xop_hi) begin
                        illegal = 1'b1;
                    end else if (x3 == YNK_POPJ) begin
                        cw.a_sel = ISEL_REGS; cw.i_f = IF_INC; cw.j_f = JF_LOAD; cw.t_f = 1'b1;
                    end else if (x3 == YNK_POPS) begin
                        cw.a_sel = ISEL_REGJ; cw.i_f = IF_INC; cw.s_f = SF_LOAD; cw.t_f = 1'b1;
                    end else if (x3[2] && (int'(x3[1:0]) < JREG_CNT)) begin
                        // Shadow J register nn is encoded straight into J_F
                        cw.a_sel = ISEL_REGS; cw.b_sel = 1'b1; cw.c_sel = 1'b1;
                        cw.f_f   = FF_SET;    cw.i_f   = IF_INC; cw.j_f  = {1'b1, x3[1:0]};
                        cw.s_f   = SF_INC;    cw.t_f   = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_DBL: begin
                    cw.a_sel = ISEL_REGS; cw.d_f = 1'b1; cw.i_f = IF_INC; cw.s_f = SF_DEC;
                end
                OP_MIN: begin
                    cw.a_sel = ISEL_REGS; cw.f_f = FF_SET; cw.i_f = IF_INC;
                    cw.s_f   = SF_INC;    cw.t_f = 1'b1;   cw.alu_f = ALU_SUB;
                end
                OP_CAL: begin
                    cw.j_f    = JF_LOAD; cw.f_f = FF_PUSH;
                    cw.i_f    = reg_f ? IF_LOAD : IF_INC;
                    taken_cal = reg_f;
                end
                default: begin
                    cw.i_f = IF_INC; cw.t_f = 1'b1; cw.alu_f = ALU_AND;
                end
            endcase
        end
        if (illegal) begin
            cw = CW_NOP;
        end
    end

endmodule

// File: rtl/forth_decoder_pipe.sv
// Forth opcode decoder: one registered control word per accepted op, with flush and sticky trap.
// Word appears one cycle after acceptance.
// Holds the word while ctrl_ready is low; op_ready drops during stall, trap or regP=0.
module forth_decoder_pipe
    import forth_pkg::*;
#(
    parameter int OP_W     = 3,
    parameter int XOP_W    = 3,
    parameter int JREG_CNT = 4,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 regP,
    input  logic                 regF,
    forth_decoder_pipe_if.slave  bus
);

    dec_state_t       state, state_nxt;
    ctrl_word_t       cw_q, tbl_cw;
    logic             ctrl_valid_q;
    logic [CNT_W-1:0] retired_q;
    logic             tbl_illegal, tbl_taken;
    logic             op_ready, accept, issue;

    forth_op_table #(.OP_W(OP_W), .XOP_W(XOP_W), .JREG_CNT(JREG_CNT)) u_table (
        .opcode    (bus.opcode),
        .xop       (bus.xop),
        .reg_f     (regF),
        .cw        (tbl_cw),
        .illegal   (tbl_illegal),
        .taken_cal (tbl_taken)
    );

    assign op_ready = regP && (state != ST_TRAP) && (!ctrl_valid_q || bus.ctrl_ready);
    assign accept   = bus.op_valid && op_ready;
    // The op following a taken CAL is swallowed, so it never issues
    assign issue    = accept && (state != ST_FLUSH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // Next state: trap_clr beats a same-cycle illegal op; FLUSH ignores legality
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (accept) begin
                    if (tbl_illegal && !bus.trap_clr) state_nxt = ST_TRAP;
                    else if (tbl_taken)               state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: if (accept)       state_nxt = ST_RUN;
            ST_TRAP:  if (bus.trap_clr) state_nxt = ST_RUN;
            default:                    state_nxt = ST_RUN;
        endcase
    end

    // Output register: load on issue, return to NOP once the word is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_valid_q <= 1'b0;
            cw_q         <= CW_NOP;
        end else if (issue) begin
            ctrl_valid_q <= 1'b1;
            cw_q         <= tbl_cw;
        end else if (bus.ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
            cw_q         <= CW_NOP;
        end
    end

    // Retired count of consumed words, free-running wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              retired_q <= '0;
        else if (ctrl_valid_q && bus.ctrl_ready) retired_q <= retired_q + CNT_W'(1);
    end

    assign bus.op_ready   = op_ready;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.A_Sel      = cw_q.a_sel;
    assign bus.B_Sel      = cw_q.b_sel;
    assign bus.C_Sel      = cw_q.c_sel;
    assign bus.D_Sel      = cw_q.d_sel;
    assign bus.D_F        = cw_q.d_f;
    assign bus.F_F        = cw_q.f_f;
    assign bus.I_F        = cw_q.i_f;
    assign bus.J_F        = cw_q.j_f;
    assign bus.S_F        = cw_q.s_f;
    assign bus.H_F        = cw_q.h_f;
    assign bus.T_F        = cw_q.t_f;
    assign bus.ALU_F      = cw_q.alu_f;
    assign bus.trap       = (state == ST_TRAP);
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_forth_decoder_pipe.sv
// Scenario bench for forth_decoder_pipe: per-feature tasks plus a word scoreboard.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A second instance with JREG_CNT=2 covers the reduced shadow-register range.
module tb_forth_decoder_pipe;
    import forth_pkg::*;

    localparam logic [2:0] T_BLK = 3'd0, T_RIT = 3'd1, T_GET = 3'd2, T_YNK = 3'd3;
    localparam logic [2:0] T_DBL = 3'd4, T_MIN = 3'd5, T_CAL = 3'd6, T_WHT = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic regP = 1'b0;
    logic regF = 1'b0;

    always #5 clk = ~clk;

    forth_decoder_pipe_if #(.OP_W(3), .XOP_W(3), .CNT_W(16)) bus ();
    forth_decoder_pipe_if #(.OP_W(3), .XOP_W(3), .CNT_W(16)) bus2 ();

    forth_decoder_pipe #(.OP_W(3), .XOP_W(3), .JREG_CNT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .regP(regP), .regF(regF), .bus(bus)
    );
    forth_decoder_pipe #(.OP_W(3), .XOP_W(3), .JREG_CNT(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .regP(regP), .regF(regF), .bus(bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;
    ctrl_word_t exp_q[$];

    // Reference decode written directly from the instruction table
    function automatic ctrl_word_t exp_word(input logic [2:0] op, input logic [2:0] x,
                                            input logic rf, input int jcnt);
        ctrl_word_t w;
        w = '0;
        w.alu_f = 2'b10;
        case (op)
            3'd0: begin w.i_f = 2'b01; w.t_f = 1'b1; w.alu_f = 2'b00; end
            3'd1: begin w.a_sel = 2'b01; w.d_f = 1'b1; w.i_f = 2'b01; w.j_f = 3'b001; end
            3'd2: begin w.a_sel = 2'b01; w.i_f = 2'b01; w.j_f = 3'b001; w.t_f = 1'b1; end
            3'd3: begin
                if (x == 3'b000) begin
                    w.a_sel = 2'b10; w.i_f = 2'b01; w.j_f = 3'b010; w.t_f = 1'b1;
                end else if (x == 3'b001) begin
                    w.a_sel = 2'b01; w.i_f = 2'b01; w.s_f = 2'b11; w.t_f = 1'b1;
                end else if (x[2] && int'(x[1:0]) < jcnt) begin
                    w.a_sel = 2'b10; w.b_sel = 1'b1; w.c_sel = 1'b1; w.f_f = 2'b01;
                    w.i_f = 2'b01; w.j_f = x; w.s_f = 2'b01; w.t_f = 1'b1;
                end
            end
            3'd4: begin w.a_sel = 2'b10; w.d_f = 1'b1; w.i_f = 2'b01; w.s_f = 2'b10; end
            3'd5: begin
                w.a_sel = 2'b10; w.f_f = 2'b01; w.i_f = 2'b01; w.s_f = 2'b01;
                w.t_f = 1'b1; w.alu_f = 2'b11;
            end
            3'd6: begin w.j_f = 3'b010; w.f_f = 2'b11; w.i_f = rf ? 2'b10 : 2'b01; end
            default: begin w.i_f = 2'b01; w.t_f = 1'b1; w.alu_f = 2'b01; end
        endcase
        return w;
    endfunction

    function automatic ctrl_word_t nop_word();
        ctrl_word_t w;
        w = '0;
        w.alu_f = 2'b10;
        return w;
    endfunction

    function automatic ctrl_word_t got_word();
        return {bus.A_Sel, bus.B_Sel, bus.C_Sel, bus.D_Sel, bus.D_F, bus.F_F,
                bus.I_F, bus.J_F, bus.S_F, bus.H_F, bus.T_F, bus.ALU_F};
    endfunction

    function automatic ctrl_word_t got_word2();
        return {bus2.A_Sel, bus2.B_Sel, bus2.C_Sel, bus2.D_Sel, bus2.D_F, bus2.F_F,
                bus2.I_F, bus2.J_F, bus2.S_F, bus2.H_F, bus2.T_F, bus2.ALU_F};
    endfunction

    // One clock: pop/compare any word consumed this cycle, report acceptance
    task automatic step(output bit acc);
        ctrl_word_t e;
        @(negedge clk);
        acc = bus.op_valid && bus.op_ready;
        if (bus.ctrl_valid && bus.ctrl_ready) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_extra: got word %h, required no word", got_word());
            end else begin
                e = exp_q.pop_front();
                if (got_word() !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_word: got %h, required %h", got_word(), e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit acc;
        step(acc);
    endtask

    // Present one op until accepted; queue its expected word if it should issue
    task automatic send(input logic [2:0] op, input logic [2:0] x, input logic rf,
                        input bit will_issue, input int jcnt);
        bit acc;
        acc = 1'b0;
        bus.op_valid = 1'b1;
        bus.opcode   = op;
        bus.xop      = x;
        regF         = rf;
        for (int i = 0; i < 20; i++) begin
            step(acc);
            if (acc) break;
        end
        n_assert++;
        if (!acc) begin
            n_fail++;
            $display("FAIL send_accept: op %0d xop %0d not accepted, required within 20 cycles", op, x);
        end else if (will_issue) begin
            exp_q.push_back(exp_word(op, x, rf, jcnt));
        end
    endtask

    task automatic test_reset();
        bus.op_valid = 1'b0; bus.opcode = '0; bus.xop = '0;
        bus.ctrl_ready = 1'b0; bus.trap_clr = 1'b0;
        bus2.op_valid = 1'b0; bus2.opcode = '0; bus2.xop = '0;
        bus2.ctrl_ready = 1'b0; bus2.trap_clr = 1'b0;
        rst_n = 1'b0; regP = 1'b0;
        #22;
        n_assert += 4;
        if (bus.ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.ctrl_valid); end
        if (got_word() !== nop_word()) begin n_fail++; $display("FAIL reset_word: got %h, required %h", got_word(), nop_word()); end
        if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b, required 0", bus.trap); end
        if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d, required 0", bus.retired); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_assert++;
        if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL regp_low_ready: got %b, required 0", bus.op_ready); end
        regP = 1'b1;
        #1;
        n_assert++;
        if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL run_ready: got %b, required 1", bus.op_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int c0;
        bus.ctrl_ready = 1'b1;
        c0 = $time / 10;
        send(T_BLK, 3'd0, 1'b0, 1'b1, 4);
        send(T_RIT, 3'd0, 1'b0, 1'b1, 4);
        send(T_GET, 3'd0, 1'b0, 1'b1, 4);
        send(T_DBL, 3'd0, 1'b0, 1'b1, 4);
        send(T_MIN, 3'd0, 1'b0, 1'b1, 4);
        send(T_WHT, 3'd0, 1'b0, 1'b1, 4);
        n_assert++;
        if (($time / 10) - c0 != 6) begin
            n_fail++;
            $display("FAIL stream_cycles: took %0d cycles, required 6", ($time / 10) - c0);
        end
        bus.op_valid = 1'b0;
        tick();
        tick();
        n_assert++;
        if (bus.retired !== 16'd6) begin n_fail++; $display("FAIL stream_retired: got %0d, required 6", bus.retired); end
    endtask

    task automatic test_stall();
        logic [15:0] r0;
        ctrl_word_t ew;
        r0 = bus.retired;
        bus.ctrl_ready = 1'b0;
        send(T_MIN, 3'd0, 1'b0, 1'b1, 4);
        bus.op_valid = 1'b0;
        ew = exp_word(T_MIN, 3'd0, 1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.ctrl_ready = 1'b1;
            n_assert += 2;
            if (bus.ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b, required 1", i, bus.ctrl_valid); end
            if (got_word() !== ew) begin n_fail++; $display("FAIL stall_word[%0d]: got %h, required %h", i, got_word(), ew); end
            if (i < 3) begin
                n_assert++;
                if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got %b, required 0", i, bus.op_ready); end
            end
            tick();
        end
        n_assert++;
        if (bus.retired !== r0 + 16'd1) begin n_fail++; $display("FAIL stall_retired: got %0d, required %0d", bus.retired, r0 + 16'd1); end
    endtask

    task automatic test_flush();
        logic [15:0] r0;
        bus.ctrl_ready = 1'b1;
        r0 = bus.retired;
        send(T_CAL, 3'd0, 1'b1, 1'b1, 4);
        send(T_GET, 3'd0, 1'b1, 1'b0, 4);
        send(T_BLK, 3'd0, 1'b1, 1'b1, 4);
        bus.op_valid = 1'b0;
        tick();
        tick();
        n_assert++;
        if (bus.retired !== r0 + 16'd2) begin n_fail++; $display("FAIL flush_taken_retired: got %0d, required %0d", bus.retired, r0 + 16'd2); end
        r0 = bus.retired;
        send(T_CAL, 3'd0, 1'b0, 1'b1, 4);
        send(T_GET, 3'd0, 1'b0, 1'b1, 4);
        send(T_BLK, 3'd0, 1'b0, 1'b1, 4);
        bus.op_valid = 1'b0;
        tick();
        tick();
        n_assert++;
        if (bus.retired !== r0 + 16'd3) begin n_fail++; $display("FAIL flush_untaken_retired: got %0d, required %0d", bus.retired, r0 + 16'd3); end
    endtask

    task automatic test_trap();
        bus.ctrl_ready = 1'b1;
        send(T_YNK, 3'b110, 1'b0, 1'b1, 4);
        send(T_YNK, 3'b011, 1'b0, 1'b1, 4);
        n_assert += 2;
        if (bus.trap !== 1'b1) begin n_fail++; $display("FAIL trap_set: got %b, required 1", bus.trap); end
        if (bus.ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL trap_nop_valid: got %b, required 1", bus.ctrl_valid); end
        bus.opcode = T_BLK;
        bus.xop    = 3'd0;
        for (int i = 0; i < 5; i++) begin
            n_assert += 2;
            if (bus.op_ready !== 1'b0) begin n_fail++; $display("FAIL trap_ready[%0d]: got %b, required 0", i, bus.op_ready); end
            if (bus.trap !== 1'b1) begin n_fail++; $display("FAIL trap_sticky[%0d]: got %b, required 1", i, bus.trap); end
            tick();
        end
        bus.op_valid = 1'b0;
        bus.trap_clr = 1'b1;
        tick();
        bus.trap_clr = 1'b0;
        n_assert += 2;
        if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL trap_clear: got %b, required 0", bus.trap); end
        if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL trap_clear_ready: got %b, required 1", bus.op_ready); end
        // trap_clr coinciding with an illegal op wins
        bus.trap_clr = 1'b1;
        send(T_YNK, 3'b010, 1'b0, 1'b1, 4);
        bus.trap_clr = 1'b0;
        n_assert += 2;
        if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL clr_priority_trap: got %b, required 0", bus.trap); end
        if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL clr_priority_ready: got %b, required 1", bus.op_ready); end
        // An illegal op swallowed by the flush slot raises nothing
        send(T_CAL, 3'd0, 1'b1, 1'b1, 4);
        send(T_YNK, 3'b011, 1'b0, 1'b0, 4);
        bus.op_valid = 1'b0;
        n_assert++;
        if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL flush_illegal_trap: got %b, required 0", bus.trap); end
        tick();
        tick();
    endtask

    task automatic test_jreg2();
        ctrl_word_t ew;
        bus2.ctrl_ready = 1'b1;
        bus2.op_valid   = 1'b1;
        bus2.opcode     = T_YNK;
        bus2.xop        = 3'b101;
        tick();
        ew = exp_word(T_YNK, 3'b101, 1'b0, 2);
        n_assert += 3;
        if (bus2.ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL jreg2_legal_valid: got %b, required 1", bus2.ctrl_valid); end
        if (got_word2() !== ew) begin n_fail++; $display("FAIL jreg2_legal_word: got %h, required %h", got_word2(), ew); end
        if (bus2.trap !== 1'b0) begin n_fail++; $display("FAIL jreg2_legal_trap: got %b, required 0", bus2.trap); end
        bus2.xop = 3'b110;
        tick();
        bus2.op_valid = 1'b0;
        ew = exp_word(T_YNK, 3'b110, 1'b0, 2);
        n_assert += 3;
        if (bus2.ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL jreg2_illegal_valid: got %b, required 1", bus2.ctrl_valid); end
        if (bus2.J_F !== ew.j_f) begin n_fail++; $display("FAIL jreg2_illegal_jf: got %b, required %b", bus2.J_F, ew.j_f); end
        if (bus2.trap !== 1'b1) begin n_fail++; $display("FAIL jreg2_illegal_trap: got %b, required 1", bus2.trap); end
    endtask

    task automatic test_reset_stall();
        bus.ctrl_ready = 1'b0;
        send(T_DBL, 3'd0, 1'b0, 1'b0, 4);
        bus.op_valid = 1'b0;
        tick();
        n_assert++;
        if (bus.ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL rststall_held: got %b, required 1", bus.ctrl_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_assert += 5;
        if (bus.ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL rststall_valid: got %b, required 0", bus.ctrl_valid); end
        if (got_word() !== nop_word()) begin n_fail++; $display("FAIL rststall_word: got %h, required %h", got_word(), nop_word()); end
        if (bus.retired !== 16'd0) begin n_fail++; $display("FAIL rststall_retired: got %0d, required 0", bus.retired); end
        if (bus.trap !== 1'b0) begin n_fail++; $display("FAIL rststall_trap: got %b, required 0", bus.trap); end
        if (bus.op_ready !== 1'b1) begin n_fail++; $display("FAIL rststall_run_ready: got %b, required 1", bus.op_ready); end
        rst_n = 1'b1;
        bus.ctrl_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_trap();
        test_jreg2();
        test_reset_stall();
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d words outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
